mips_execute_mul_div: RTL and testbench
=======================================

Name: mips_execute_mul_div

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the instruction categorizer.
- Consumes the categorizer's mulDiv and hilo flags together with the R-format funct field and the operand values.
- Executes MULT/MULTU/DIV/DIVU iteratively, owns the HI/LO architectural registers, serves MFHI/MFLO/MTHI/MTLO, and raises a pipeline stall while a prior operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid  input  1  EX-stage instruction is real (not a bubble or flushed).
- mulDiv  input  1  categorizer mulDiv flag (funct 011???).
- hilo  input  1  categorizer hilo flag (funct 010???).
- func  input  6  R-format funct field.
- a  input  WIDTH  rs operand value.
- b  input  WIDTH  rt operand value.
- result  output  WIDTH  combinational: HI for MFHI, LO for MFLO, else 0.
- stall  output  1  combinational: valid & (mulDiv | hilo) & busy.
- busy  output  1  registered: operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, active-high): state IDLE; busy=0; hi=0; lo=0; all internal accumulators, counter and sign flags cleared. Reset mid-operation aborts it with no HI/LO update.
- accept = valid & ~stall.
- Decode, only when accept:
  - mulDiv & func[1]=0: multiply.
  - mulDiv & func[1]=1: divide.
  - func[0]=0: signed; func[0]=1: unsigned.
  - hilo & func=010001: MTHI, hi<=a at the same edge.
  - hilo & func=010011: MTLO, lo<=a at the same edge.
  - MFHI (010000) / MFLO (010010): no state change; result is combinational from the current hi/lo.
  - Other 011??? codes (e.g. 011100+): ignored, no state change.
- States:
  - IDLE: on accepting mul or div, latch operand magnitudes (two's-complement absolute value if signed and negative) and the result sign flags. Go to MUL or DIV; counter=0; busy<=1.
  - MUL: shift-add, one bit per cycle, 2*WIDTH-bit product. After WIDTH cycles go to FIX.
  - DIV: restoring division, one quotient bit per cycle. After WIDTH cycles go to FIX.
  - FIX: 1 cycle. Apply sign correction.
    - Multiply: negate the 2*WIDTH product if signs differ.
    - Divide: quotient negated if signs differ; remainder takes the sign of a.
    - Write hi/lo (multiply: hi=upper, lo=lower; divide: hi=remainder, lo=quotient). busy<=0, go to IDLE.
- Latency: accept at edge ending cycle N. busy=1 in cycles N+1..N+WIDTH+1 (33 cycles for WIDTH=32). New HI/LO are visible in cycle N+WIDTH+2.
- Stall:
  - Any mulDiv/hilo instruction presented while busy is stalled, including MFxx, MTxx and a new mult/div. It is accepted in the first cycle busy=0.
  - Non-mulDiv/non-hilo instructions never stall and proceed while busy.
- Unsigned operands are never negated; unsigned and signed share the datapath.
- Divide by zero: no trap; the natural algorithm result is then sign-corrected.
  - divu: hi=a, lo=all ones.
  - div: hi=a, lo = 1 if a negative, else all ones.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- valid=0 never changes state and forces stall=0.

Test Plan:
- mult a=7, b=0xFFFFFFFD -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. mult with the same operands -> hi=0, lo=1.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/0 -> hi=100, lo=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mult 3*5, then MFLO held valid the next cycle -> stall=1 for 33 cycles; the first cycle with stall=0 gives result=15. An add-category instruction during busy -> stall=0.
- MTHI a=0x12345678 while idle -> hi updates next edge; MFHI next cycle -> result=0x12345678. MTLO while busy -> stalled, lo unchanged until after FIX.
- Assert reset at cycle 10 of a divu -> busy=0, hi=lo=0 immediately. The next mult after release completes normally.

Source files
------------

// File: rtl/mips_execute_mul_div_if.sv
// Bus bundle between the EX-stage issue logic and the multiply/divide unit.
// The master drives the decoded instruction and operands. The slave returns
// the HI/LO state, the MFHI/MFLO result and the stall request.
interface mips_execute_mul_div_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             mulDiv;
  logic             hilo;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output valid, mulDiv, hilo, func, a, b,
    input  result, stall, busy, hi, lo
  );

  modport slave (
    input  valid, mulDiv, hilo, func, a, b,
    output result, stall, busy, hi, lo
  );
endinterface

// File: rtl/mips_execute_mul_div.sv
// Iterative MIPS multiply/divide unit.
// The unit owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both work on
// operand magnitudes, produce one bit per cycle, and spend one extra cycle
// applying the sign correction.
module mips_execute_mul_div #(
  parameter int WIDTH = 32
) (
  input logic                   clock,
  input logic                   reset,
  mips_execute_mul_div_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             r_state;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_isDiv;
  logic               r_negRes;
  logic               r_negRem;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;

  logic               w_accept;
  logic               w_signed;
  logic               w_doMul;
  logic               w_doDiv;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_mfhi;
  logic               w_mflo;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_diff;
  logic               w_geq;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  // Any HI/LO-touching instruction waits while an operation is in flight.
  assign bus.stall = bus.valid & (bus.mulDiv | bus.hilo) & r_busy;
  assign w_accept  = bus.valid & ~bus.stall;

  // The 011??? codes with bit 2 set are not MIPS multiply/divide ops, so they are ignored.
  assign w_signed = ~bus.func[0];
  assign w_doMul  = w_accept & bus.mulDiv & (bus.func[5:2] == 4'b0110) & ~bus.func[1];
  assign w_doDiv  = w_accept & bus.mulDiv & (bus.func[5:2] == 4'b0110) &  bus.func[1];
  assign w_mthi   = w_accept & bus.hilo & (bus.func == 6'b010001);
  assign w_mtlo   = w_accept & bus.hilo & (bus.func == 6'b010011);
  assign w_mfhi   = bus.hilo & (bus.func == 6'b010000);
  assign w_mflo   = bus.hilo & (bus.func == 6'b010010);

  // Magnitudes feed the shared unsigned datapath. Unsigned ops are never negated.
  assign w_aMag = (w_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_bMag = (w_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One restoring-division step: bring in the next dividend bit and try to subtract.
  // A zero divisor always "fits", which gives the all-ones quotient and rem = dividend.
  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, r_divisor};
  assign w_geq     = (w_shifted >= {1'b0, r_divisor});

  // Sign correction. The remainder follows the dividend and the quotient follows the sign XOR.
  assign w_prodFix = r_negRes ? -r_prod : r_prod;
  assign w_quoFix  = r_negRes ? -r_quo  : r_quo;
  assign w_remFix  = r_negRem ? -r_rem  : r_rem;

  assign bus.result = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);
  assign bus.busy   = r_busy;
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;

  // Control FSM plus datapath. It owns HI/LO and runs one iteration per cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_prod    <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mthi) r_hi <= bus.a;
          if (w_mtlo) r_lo <= bus.a;
          if (w_doMul | w_doDiv) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_isDiv   <= w_doDiv;
            r_negRes  <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_negRem  <= w_signed & bus.a[WIDTH-1];
            r_mcand   <= {{WIDTH{1'b0}}, w_aMag};
            r_mplier  <= w_bMag;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= w_aMag;
            r_divisor <= w_bMag;
            r_state   <= w_doMul ? MUL : DIV;
          end
        end
        MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= FIX;
        end
        DIV: begin
          r_rem <= w_geq ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_geq};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= FIX;
        end
        FIX: begin
          if (r_isDiv) begin
            r_hi <= w_remFix;
            r_lo <= w_quoFix;
          end else begin
            r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFix[WIDTH-1:0];
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_execute_mul_div.sv
// Self-checking bench for mips_execute_mul_div.
// A cycle-level behavioural model computes the whole HI/LO result with plain
// arithmetic when an operation is accepted. It then reveals that result after
// the fixed latency. Every cycle the DUT outputs are compared against this
// model, and directed scenarios also check hand-computed literal values.
module tb_mips_execute_mul_div;

  localparam int WIDTH = 32;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  mips_execute_mul_div_if #(.WIDTH(WIDTH)) bus ();

  mips_execute_mul_div #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model state: architectural HI/LO, remaining busy cycles, and the pending result.
  logic [31:0] mHi;
  logic [31:0] mLo;
  int          mLeft;
  logic [31:0] pendHi;
  logic [31:0] pendLo;

  // Sampled DUT outputs from the most recent compare point.
  logic        sBusy;
  logic        sStall;
  logic [31:0] sResult;
  logic [31:0] sHi;
  logic [31:0] sLo;

  function automatic logic [63:0] modelMul(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  // Returns {hi, lo} = {remainder, quotient}.
  function automatic logic [63:0] modelDiv(input logic [31:0] x, input logic [31:0] y, input logic s);
    int sx;
    int sy;
    if (y == 32'h0)
      return {x, (s && x[31]) ? 32'h1 : 32'hFFFFFFFF};
    if (s && x == 32'h80000000 && y == 32'hFFFFFFFF)
      return {32'h0, 32'h80000000};
    if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {x % y, x / y};
  endfunction

  // Behavioural model: decides acceptance, computes results up front, and releases them after WIDTH+1 busy cycles.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mHi    <= '0;
      mLo    <= '0;
      mLeft  <= 0;
      pendHi <= '0;
      pendLo <= '0;
    end else begin
      if (mLeft > 0) begin
        mLeft <= mLeft - 1;
        if (mLeft == 1) begin
          mHi <= pendHi;
          mLo <= pendLo;
        end
      end
      if (bus.valid && !((bus.mulDiv || bus.hilo) && mLeft > 0)) begin
        if (bus.hilo && bus.func == 6'h11) mHi <= bus.a;
        if (bus.hilo && bus.func == 6'h13) mLo <= bus.a;
        if (bus.mulDiv && bus.func[5:2] == 4'b0110) begin
          if (bus.func[1]) {pendHi, pendLo} <= modelDiv(bus.a, bus.b, ~bus.func[0]);
          else             {pendHi, pendLo} <= modelMul(bus.a, bus.b, ~bus.func[0]);
          mLeft <= WIDTH + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    bus.valid  = v;
    bus.func   = f;
    bus.mulDiv = (f[5:3] == 3'b011);
    bus.hilo   = (f[5:3] == 3'b010);
    bus.a      = x;
    bus.b      = y;
  endtask

  // One clock cycle. Compare just before the rising edge, then return 1 unit after it.
  task automatic step();
    logic [31:0] expRes;
    @(negedge clock);
    #2;
    sBusy   = bus.busy;
    sStall  = bus.stall;
    sResult = bus.result;
    sHi     = bus.hi;
    sLo     = bus.lo;
    expRes  = (bus.hilo && bus.func == 6'h10) ? mHi :
              (bus.hilo && bus.func == 6'h12) ? mLo : 32'h0;
    checkOutput("busy",   32'(sBusy),  32'(mLeft > 0));
    checkOutput("stall",  32'(sStall), 32'(bus.valid && (bus.mulDiv || bus.hilo) && mLeft > 0));
    checkOutput("result", sResult, expRes);
    checkOutput("hi",     sHi, mHi);
    checkOutput("lo",     sLo, mLo);
    @(posedge clock);
    #1;
  endtask

  // Present an instruction until it is accepted, then return the bus to a bubble.
  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic done;
    logic wasStalled;
    done = 1'b0;
    applyStimulus(1'b1, f, x, y);
    for (int i = 0; i < 100 && !done; i++) begin
      wasStalled = (bus.mulDiv || bus.hilo) && mLeft > 0;
      step();
      if (!wasStalled) done = 1'b1;
    end
    checkOutput("issueTimeout", 32'(done), 32'h1);
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
  endtask

  // Step until the model reports idle, counting cycles in which the DUT showed busy.
  task automatic waitIdle(inout int n);
    for (int i = 0; i < 200 && mLeft > 0; i++) begin
      step();
      if (sBusy) n++;
    end
    checkOutput("idleTimeout", 32'(mLeft), 32'h0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [5:0] ops [10];
    ops = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h1C, 6'h20};
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    @(posedge clock);
    #1;
    step();
    step();
    reset = 1'b0;
    step();
    checkOutput("resetBusy", 32'(sBusy), 32'h0);
    checkOutput("resetHi", sHi, 32'h0);
    checkOutput("resetLo", sLo, 32'h0);

    // mult 7 * -3. An add-category instruction during busy never stalls.
    issue(6'h18, 32'd7, 32'hFFFFFFFD);
    applyStimulus(1'b1, 6'h20, 32'h1, 32'h2);
    step();
    checkOutput("addNoStall", 32'(sStall), 32'h0);
    n = sBusy ? 1 : 0;
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    waitIdle(n);
    checkOutput("multBusyCycles", 32'(n), 32'd33);
    step();
    checkOutput("multHi", sHi, 32'hFFFFFFFF);
    checkOutput("multLo", sLo, 32'hFFFFFFEB);

    n = 0;
    issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle(n);
    step();
    checkOutput("multuHi", sHi, 32'hFFFFFFFE);
    checkOutput("multuLo", sLo, 32'h00000001);
    issue(6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle(n);
    step();
    checkOutput("multNegHi", sHi, 32'h0);
    checkOutput("multNegLo", sLo, 32'h1);

    issue(6'h1A, 32'hFFFFFFF9, 32'd2);
    waitIdle(n);
    step();
    checkOutput("divHi", sHi, 32'hFFFFFFFF);
    checkOutput("divLo", sLo, 32'hFFFFFFFD);
    issue(6'h1B, 32'd100, 32'd0);
    waitIdle(n);
    step();
    checkOutput("divuZeroHi", sHi, 32'd100);
    checkOutput("divuZeroLo", sLo, 32'hFFFFFFFF);
    issue(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    waitIdle(n);
    step();
    checkOutput("divOvfHi", sHi, 32'h0);
    checkOutput("divOvfLo", sLo, 32'h80000000);

    // mult 3*5 followed by an MFLO held valid: it stalls for the whole busy window.
    issue(6'h18, 32'd3, 32'd5);
    applyStimulus(1'b1, 6'h12, 32'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!sStall) break;
      n++;
    end
    checkOutput("mfloStallCycles", 32'(n), 32'd33);
    checkOutput("mfloResult", sResult, 32'd15);
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);

    // MTHI while idle, then MFHI on the next cycle.
    issue(6'h11, 32'h12345678, 32'h0);
    applyStimulus(1'b1, 6'h10, 32'h0, 32'h0);
    step();
    checkOutput("mfhiResult", sResult, 32'h12345678);
    checkOutput("mthiHi", sHi, 32'h12345678);

    // MTLO while busy is held off until FIX has written lo.
    issue(6'h18, 32'd2, 32'd3);
    issue(6'h13, 32'hAAAA5555, 32'h0);
    checkOutput("mtloAfterFixLo", sLo, 32'd6);
    step();
    checkOutput("mtloLo", sLo, 32'hAAAA5555);

    // Reset in the middle of a divu aborts the operation immediately.
    issue(6'h1B, 32'd1000, 32'd7);
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    #1;
    checkOutput("abortBusy", 32'(bus.busy), 32'h0);
    checkOutput("abortHi", bus.hi, 32'h0);
    checkOutput("abortLo", bus.lo, 32'h0);
    step();
    reset = 1'b0;
    step();
    n = 0;
    issue(6'h18, 32'd6, 32'd7);
    waitIdle(n);
    step();
    checkOutput("postResetHi", sHi, 32'h0);
    checkOutput("postResetLo", sLo, 32'd42);

    // Random instruction mix, including bubbles, stalled requests and ignored codes.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 9)], pickOperand(), pickOperand());
      step();
    end
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    waitIdle(n);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
